// File: rtl/nonce_sched_if.sv
// Handshake bundle between the nonce scheduler (master) and one SHA256 core (slave).
interface nonce_sched_if;
  logic         core_start;
  logic         core_reset;
  logic [31:0]  core_nonce;
  logic         core_done;
  logic [255:0] core_hash;

  modport master (
    output core_start,
    output core_reset,
    output core_nonce,
    input  core_done,
    input  core_hash
  );

  modport slave (
    input  core_start,
    input  core_reset,
    input  core_nonce,
    output core_done,
    output core_hash
  );
endinterface

// File: rtl/nonce_sched.sv
// Nonce sweep scheduler: issues nonces to a SHA256 core and stops on a hash below target.
// Optional WAIT watchdog with bounded retries is enabled by defining NONCE_SCHED_WATCHDOG_EN.
module nonce_sched #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_start,
  input  logic          cfg_abort,
  input  logic [31:0]   nonce_first,
  input  logic [31:0]   nonce_last,
  input  logic [255:0]  target,
  output logic          busy,
  output logic          found,
  output logic          exhausted,
  output logic          error,
  output logic [31:0]   found_nonce,
  output logic [31:0]   attempts,
  nonce_sched_if.master core
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_t;

  state_t         state_reg;
  logic [31:0]    cur_nonce_reg;
  logic [31:0]    last_reg;
  logic [255:0]   target_reg;
  logic [255:0]   hash_reg;
  logic [31:0]    found_nonce_reg;
  logic [31:0]    attempts_reg;
  logic           core_start_reg;
  logic           core_reset_reg;
  logic           found_reg;
  logic           exhausted_reg;

`ifdef NONCE_SCHED_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic [TW-1:0]  timer_reg;
  logic [RW-1:0]  retry_reg;
  logic           error_reg;
  logic           timeout;
  logic           retry_left;

  assign timeout    = (timer_reg == TW'(TIMEOUT_CYC - 1));
  assign retry_left = ((int'(retry_reg) + 1) < MAX_RETRY);
  assign error      = error_reg;
`else
  logic unused_params;
  assign unused_params = ^{TIMEOUT_CYC, MAX_RETRY};
  assign error         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cur_nonce_reg   <= '0;
      last_reg        <= '0;
      target_reg      <= '0;
      hash_reg        <= '0;
      found_nonce_reg <= '0;
      attempts_reg    <= '0;
      core_start_reg  <= 1'b0;
      core_reset_reg  <= 1'b0;
      found_reg       <= 1'b0;
      exhausted_reg   <= 1'b0;
`ifdef NONCE_SCHED_WATCHDOG_EN
      timer_reg       <= '0;
      retry_reg       <= '0;
      error_reg       <= 1'b0;
`endif
    end else begin
      core_reset_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            cur_nonce_reg   <= nonce_first;
            last_reg        <= nonce_last;
            target_reg      <= target;
            found_reg       <= 1'b0;
            exhausted_reg   <= 1'b0;
            found_nonce_reg <= '0;
            attempts_reg    <= '0;
            core_start_reg  <= 1'b1;
            state_reg       <= ISSUE;
`ifdef NONCE_SCHED_WATCHDOG_EN
            error_reg       <= 1'b0;
            retry_reg       <= '0;
`endif
          end
        end

        // A watchdog retry lands here with core_start low, so ISSUE then
        // spends one extra cycle to keep start and core reset apart.
        ISSUE: begin
          if (cfg_abort) begin
            core_reset_reg <= 1'b1;
            core_start_reg <= 1'b0;
            state_reg      <= IDLE;
          end else if (core_start_reg) begin
            core_start_reg <= 1'b0;
            state_reg      <= WAIT;
`ifdef NONCE_SCHED_WATCHDOG_EN
            timer_reg      <= '0;
`endif
          end else begin
            core_start_reg <= 1'b1;
          end
        end

        WAIT: begin
          if (cfg_abort) begin
            core_reset_reg <= 1'b1;
            state_reg      <= IDLE;
          end else if (core.core_done) begin
            hash_reg  <= core.core_hash;
            state_reg <= CHECK;
            if (attempts_reg != 32'hFFFF_FFFF) begin
              attempts_reg <= attempts_reg + 32'd1;
            end
`ifdef NONCE_SCHED_WATCHDOG_EN
            retry_reg <= '0;
          end else if (timeout) begin
            core_reset_reg <= 1'b1;
            retry_reg      <= retry_reg + RW'(1);
            if (retry_left) begin
              state_reg <= ISSUE;
            end else begin
              error_reg <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
`endif
          end
        end

        CHECK: begin
          if (cfg_abort) begin
            core_reset_reg <= 1'b1;
            state_reg      <= IDLE;
          end else if (hash_reg < target_reg) begin
            found_reg       <= 1'b1;
            found_nonce_reg <= cur_nonce_reg;
            state_reg       <= IDLE;
          end else if (cur_nonce_reg == last_reg) begin
            exhausted_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            cur_nonce_reg  <= cur_nonce_reg + 32'd1;
            core_start_reg <= 1'b1;
            state_reg      <= ISSUE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy            = (state_reg != IDLE);
  assign found           = found_reg;
  assign exhausted       = exhausted_reg;
  assign found_nonce     = found_nonce_reg;
  assign attempts        = attempts_reg;
  assign core.core_start = core_start_reg;
  assign core.core_reset = core_reset_reg;
  assign core.core_nonce = cur_nonce_reg;

endmodule

// File: doc/nonce_sched.md
NONCE_SCHED -- requirements
Module: nonce_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, SHALL set the max cycles in WAIT before the watchdog fires.
REQ-002 Parameter MAX_RETRY, default 3, SHALL set the max watchdog retries per nonce before error.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_start  in  1  single-cycle pulse, begin sweep.
REQ-006 cfg_abort  in  1  single-cycle pulse, stop sweep.
REQ-007 nonce_first / nonce_last  in  32 each  inclusive sweep bounds.
REQ-008 target  in  256  unsigned hash threshold.
REQ-009 core_start  out  1  one-cycle start to SHA256 core.
REQ-010 core_reset  out  1  one-cycle reset to SHA256 core.
REQ-011 core_nonce  out  32  nonce driven to the block builder.
REQ-012 core_done / core_hash  in  1 / 256  core completion and result.
REQ-013 busy, found, exhausted, error  out  1 each  status.
REQ-014 found_nonce  out  32; attempts  out  32  winning nonce; completed-hash count.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, CHECK; busy SHALL be 1 in all states except IDLE.
REQ-016 IDLE + cfg_start: latch nonce_first into cur_nonce; latch nonce_last and target; clear found/exhausted/error/attempts/found_nonce; go to ISSUE.
REQ-017 cfg_start while busy SHALL be ignored.
REQ-018 ISSUE: core_start=1 for exactly one cycle; clear the WAIT timer; go to WAIT.
REQ-019 core_nonce SHALL equal cur_nonce and stay stable from ISSUE through CHECK.
REQ-020 Latency: core_start SHALL assert the cycle after cfg_start is sampled.
REQ-021 WAIT + core_done: register core_hash; go to CHECK. core_done outside WAIT SHALL be ignored.
REQ-022 CHECK, core_hash < target (unsigned): found=1, found_nonce=cur_nonce, go to IDLE.
REQ-023 CHECK, else if cur_nonce == nonce_last: exhausted=1, go to IDLE.
REQ-024 CHECK, else: cur_nonce+1 mod 2^32 (0xFFFFFFFF wraps to 0); go to ISSUE.
REQ-025 The REQ-024 path SHALL give core_start exactly 2 cycles after the core_done cycle.
REQ-026 nonce_last < nonce_first SHALL sweep through the wrap to nonce_last.
REQ-027 nonce_first == nonce_last SHALL perform exactly one hash.
REQ-028 attempts SHALL increment on every CHECK entry and saturate at 0xFFFFFFFF.
REQ-029 cfg_abort in any non-IDLE state: core_reset=1 for one cycle, go to IDLE, set no flag.
REQ-030 cfg_abort SHALL take priority over a coincident core_done.
REQ-031 found/exhausted/error/found_nonce/attempts SHALL hold in IDLE until the next accepted cfg_start.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE.
REQ-033 reset_n low SHALL zero all outputs, cur_nonce, timer and retry counter.
REQ-034 Reset mid-sweep SHALL discard all progress; no core_start until a new cfg_start after release.

Configuration
REQ-035 Macro NONCE_SCHED_WATCHDOG_EN defined: if WAIT lasts TIMEOUT_CYC cycles without core_done, pulse core_reset one cycle and increment retry.
REQ-036 NONCE_SCHED_WATCHDOG_EN defined: retry < MAX_RETRY SHALL re-enter ISSUE with the same cur_nonce; otherwise error=1 and go to IDLE.
REQ-037 NONCE_SCHED_WATCHDOG_EN defined: the retry count SHALL clear on each CHECK entry.
REQ-038 NONCE_SCHED_WATCHDOG_EN undefined: WAIT SHALL wait indefinitely; error SHALL be tied 0; no timer or retry logic.

Verification
REQ-039 first=5, last=9, target=2^256-1 -> one core_start (nonce 5), found=1, found_nonce=5, attempts=1.
REQ-040 first=0xFFFFFFFE, last=1, target=0, core done after 10 cycles -> nonces FFFFFFFE, FFFFFFFF, 0, 1 issued; exhausted=1, attempts=4.
REQ-041 Hash below target only for nonce 7, first=3 -> found_nonce=7, attempts=5; second cfg_start while busy -> no effect.
REQ-042 cfg_abort on the same cycle as core_done -> one core_reset pulse, IDLE next cycle, found=exhausted=0.
REQ-043 Watchdog enabled, TIMEOUT_CYC=16, core never done -> 3 core_reset pulses 16+ cycles apart, then error=1, busy=0.
REQ-044 reset_n low for 1 cycle mid-WAIT -> busy=0, outputs 0 immediately; no core_start until a new cfg_start.
